// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong reorder buffer that turns bit-reversed FFT output
// frames into natural-order samples behind a ready/valid output register.
module fft_reorder #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic         out_start,
    output logic [W-1:0] out_data,
    output logic [N-1:0] out_idx,
    output logic         overflow,
    output logic         frame_err
);
    localparam int           DEPTH = 1 << N;
    localparam logic [N-1:0] LAST  = {N{1'b1}};

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
    typedef enum logic {W_IDLE, W_WRITE} wr_state_t;
    typedef enum logic {R_IDLE, R_READ} rd_state_t;

    bank_state_t  bank_st [2];
    wr_state_t    wr_st;
    rd_state_t    rd_st;
    logic [N-1:0] wcnt;
    logic         wbank;
    logic         rbank;
    logic         oldest;
    logic [W-1:0] mem [2][DEPTH];

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    logic         advance;
    logic         release_rd;
    logic         start_hit;
    logic         claim;
    logic         drop;
    logic         restart;
    logic         claim_bank;
    logic         wr_en;
    logic         wr_bank;
    logic [N-1:0] wr_addr;
    logic [1:0]   is_full;
    logic [1:0]   bank_free;
    logic         rd_avail;
    logic         rd_sel;

    always_comb begin
        advance    = out_ready || !out_valid;
        release_rd = (rd_st == R_READ) && out_ready && (out_idx == LAST);
        // A bank finishing its drain this cycle may be claimed by the writer at once.
        for (int b = 0; b < 2; b++) begin
            is_full[b]   = (bank_st[b] == FULL);
            bank_free[b] = (bank_st[b] == EMPTY) || (release_rd && (rbank == 1'(b)));
        end
        start_hit  = in_valid && in_start;
        claim      = (wr_st == W_IDLE) && start_hit && (|bank_free);
        drop       = (wr_st == W_IDLE) && start_hit && !(|bank_free);
        restart    = (wr_st == W_WRITE) && start_hit;
        claim_bank = !bank_free[0];
        wr_en      = claim || ((wr_st == W_WRITE) && in_valid);
        wr_bank    = (wr_st == W_IDLE) ? claim_bank : wbank;
        wr_addr    = in_start ? '0 : bitrev(wcnt);
        rd_avail   = |is_full;
        rd_sel     = (is_full[0] && is_full[1]) ? oldest : is_full[1];
    end

    // NOTE: the sample array has no reset; bank state alone decides what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st      <= W_IDLE;
            rd_st      <= R_IDLE;
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wcnt       <= '0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            oldest     <= 1'b0;
            out_valid  <= 1'b0;
            out_start  <= 1'b0;
            out_idx    <= '0;
            out_data   <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // NOTE: read side is written first so that a same-cycle claim below overrides a release.
            case (rd_st)
                R_IDLE: begin
                    if (advance && rd_avail) begin
                        rd_st           <= R_READ;
                        rbank           <= rd_sel;
                        bank_st[rd_sel] <= DRAINING;
                        out_valid       <= 1'b1;
                        out_start       <= 1'b1;
                        out_idx         <= '0;
                        out_data        <= mem[rd_sel][0];
                    end
                end
                R_READ: begin
                    if (out_ready) begin
                        if (out_idx == LAST) begin
                            bank_st[rbank] <= EMPTY;
                            if (is_full[~rbank]) begin
                                rbank           <= ~rbank;
                                bank_st[~rbank] <= DRAINING;
                                out_start       <= 1'b1;
                                out_idx         <= '0;
                                out_data        <= mem[~rbank][0];
                            end else begin
                                rd_st     <= R_IDLE;
                                out_valid <= 1'b0;
                                out_start <= 1'b0;
                            end
                        end else begin
                            out_start <= 1'b0;
                            out_idx   <= out_idx + 1'b1;
                            out_data  <= mem[rbank][out_idx + 1'b1];
                        end
                    end
                end
                default: rd_st <= R_IDLE;
            endcase

            case (wr_st)
                W_IDLE: begin
                    if (claim) begin
                        bank_st[claim_bank] <= FILLING;
                        wbank               <= claim_bank;
                        wcnt                <= N'(1);
                        wr_st               <= W_WRITE;
                    end else if (drop) begin
                        overflow <= 1'b1;
                    end
                end
                W_WRITE: begin
                    if (restart) begin
                        frame_err <= 1'b1;
                        wcnt      <= N'(1);
                    end else if (in_valid) begin
                        if (wcnt == LAST) begin
                            bank_st[wbank] <= FULL;
                            wr_st          <= W_IDLE;
                            wcnt           <= '0;
                            // Only matters when both banks are FULL: the earlier one drains first.
                            oldest         <= is_full[~wbank] ? ~wbank : wbank;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                default: wr_st <= W_IDLE;
            endcase
        end
    end
endmodule
